// File: rtl/rob_multi.sv
// rob_multi: multi-lane reorder buffer with dispatch, CDB completion,
// in-order retire and tag-based squash recovery.
module rob_multi #(
    parameter int DEPTH  = 16,
    parameter int DP_W   = 2,
    parameter int RT_W   = 2,
    parameter int CDB_W  = 2,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DP_W-1:0]         dp_valid,
    input  logic [DP_W-1:0]         dp_has_dest,
    input  logic [DP_W*REG_W-1:0]   dp_dest,
    output logic [DP_W*TAG_W-1:0]   dp_tag,
    output logic [TAG_W:0]          dp_free,
    output logic                    dp_accept,
    input  logic [CDB_W-1:0]        cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]  cdb_tag,
    input  logic [CDB_W*DATA_W-1:0] cdb_value,
    output logic [RT_W-1:0]         rt_valid,
    output logic [RT_W*TAG_W-1:0]   rt_tag,
    output logic [RT_W-1:0]         rt_has_dest,
    output logic [RT_W*REG_W-1:0]   rt_dest,
    output logic [RT_W*DATA_W-1:0]  rt_value,
    input  logic                    squash_valid,
    input  logic [TAG_W-1:0]        squash_tag,
    output logic [TAG_W-1:0]        head_tag,
    output logic [TAG_W:0]          count
);
    localparam int CW = TAG_W + 1;

    logic [DEPTH-1:0]  occ_q, occ_d, cmp_q, cmp_d, hd_q, hd_d;
    logic [REG_W-1:0]  dst_q [DEPTH];
    logic [REG_W-1:0]  dst_d [DEPTH];
    logic [DATA_W-1:0] val_q [DEPTH];
    logic [DATA_W-1:0] val_d [DEPTH];
    logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic [CW-1:0]     n_dp, n_rt;
    logic              contig, sq_ok, go;
    logic [TAG_W-1:0]  sq_off, rt_t, dt, ct, rc, off;

    always_comb begin
        n_dp = '0;
        for (int i = 0; i < DP_W; i++)
            n_dp = n_dp + CW'(dp_valid[i]);
        contig = ((dp_valid & (dp_valid + DP_W'(1))) == '0);
        dp_free = CW'(DEPTH) - count_q;
        sq_ok = squash_valid && occ_q[squash_tag];
        sq_off = squash_tag - head_q;
        dp_accept = !reset && n_dp != '0 && contig && n_dp <= dp_free && !squash_valid;
        for (int i = 0; i < DP_W; i++)
            dp_tag[i*TAG_W +: TAG_W] = tail_q + TAG_W'(i);
    end

    // Retire lanes stop at the first incomplete entry and never reach past a squash point.
    always_comb begin
        n_rt = '0;
        go = 1'b1;
        rt_t = '0;
        rt_valid = '0;
        rt_tag = '0;
        rt_has_dest = '0;
        rt_dest = '0;
        rt_value = '0;
        for (int i = 0; i < RT_W; i++) begin
            rt_t = head_q + TAG_W'(i);
            go = go && occ_q[rt_t] && cmp_q[rt_t] && !(sq_ok && TAG_W'(i) > sq_off);
            rt_valid[i] = go;
            n_rt = n_rt + CW'(go);
            rt_tag[i*TAG_W +: TAG_W] = go ? rt_t : '0;
            rt_has_dest[i] = go && hd_q[rt_t];
            rt_dest[i*REG_W +: REG_W] = go ? dst_q[rt_t] : '0;
            rt_value[i*DATA_W +: DATA_W] = go ? val_q[rt_t] : '0;
        end
    end

    always_comb begin
        occ_d = occ_q;
        cmp_d = cmp_q;
        hd_d = hd_q;
        dst_d = dst_q;
        val_d = val_q;
        dt = '0;
        ct = '0;
        rc = '0;
        off = '0;
        for (int i = 0; i < DP_W; i++) begin
            dt = tail_q + TAG_W'(i);
            if (dp_accept && dp_valid[i]) begin
                occ_d[dt] = 1'b1;
                cmp_d[dt] = 1'b0;
                hd_d[dt] = dp_has_dest[i];
                dst_d[dt] = dp_dest[i*REG_W +: REG_W];
                val_d[dt] = '0;
            end
        end
        for (int i = 0; i < CDB_W; i++) begin
            ct = cdb_tag[i*TAG_W +: TAG_W];
            if (cdb_valid[i] && occ_q[ct]) begin
                cmp_d[ct] = 1'b1;
                val_d[ct] = cdb_value[i*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < RT_W; i++) begin
            rc = rt_tag[i*TAG_W +: TAG_W];
            if (rt_valid[i]) begin
                occ_d[rc] = 1'b0;
                cmp_d[rc] = 1'b0;
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            off = TAG_W'(j) - head_q;
            if (sq_ok && off > sq_off) begin
                occ_d[j] = 1'b0;
                cmp_d[j] = 1'b0;
            end
        end
        head_d = head_q + TAG_W'(n_rt);
        tail_d = sq_ok ? squash_tag + TAG_W'(1) : dp_accept ? tail_q + TAG_W'(n_dp) : tail_q;
        count_d = sq_ok ? CW'(sq_off) + CW'(1) - n_rt
                        : count_q + (dp_accept ? n_dp : CW'(0)) - n_rt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
            cmp_q <= '0;
            hd_q <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                dst_q[j] <= '0;
                val_q[j] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
        end else begin
            occ_q <= occ_d;
            cmp_q <= cmp_d;
            hd_q <= hd_d;
            dst_q <= dst_d;
            val_q <= val_d;
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_tag = head_q;
    assign count = count_q;
endmodule

// File: doc/rob_multi.md
ROB_MULTI -- requirements
Module: rob_multi

Interface
REQ-001 Parameters (name, default, meaning): DEPTH, 16, entry count, power of 2, >=4 | DP_W, 2, dispatch lanes | RT_W, 2, retire lanes | CDB_W, 2, completion broadcast lanes | DATA_W, 32, result width | REG_W, 5, arch register index width | TAG_W, $clog2(DEPTH), tag width.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 Ports (name direction width meaning):
- clock  in  1  rising-edge clock
- reset  in  1  async active-high reset
- dp_valid  in  DP_W  dispatch request per lane, contiguous from lane 0
- dp_has_dest  in  DP_W  lane writes a register
- dp_dest  in  DP_W*REG_W  destination register per lane
- dp_tag  out  DP_W*TAG_W  tag assigned to each lane this cycle
- dp_free  out  TAG_W+1  free entries
- dp_accept  out  1  this cycle's dispatch group accepted
- cdb_valid  in  CDB_W  broadcast valid per lane
- cdb_tag  in  CDB_W*TAG_W  completing tag
- cdb_value  in  CDB_W*DATA_W  result value
- rt_valid  out  RT_W  retiring entry per lane, lane 0 oldest
- rt_tag  out  RT_W*TAG_W  retiring tag
- rt_has_dest  out  RT_W  retiring entry writes a register
- rt_dest  out  RT_W*REG_W  retiring destination
- rt_value  out  RT_W*DATA_W  retiring value
- squash_valid  in  1  mispredict recovery request
- squash_tag  in  TAG_W  youngest surviving entry
- head_tag  out  TAG_W  oldest entry tag
- count  out  TAG_W+1  occupied entries

Function
REQ-004 Storage: circular buffer of DEPTH entries {occupied, complete, has_dest, dest, value}; tag = entry index; all DEPTH entries usable (occupancy tracked by count, no spare slot).
REQ-005 empty = (count==0); full = (count==DEPTH); dp_free = DEPTH - count, from registered state only (no same-cycle retire bypass).
REQ-006 Dispatch all-or-nothing: dp_accept = popcount(dp_valid)!=0 && popcount(dp_valid)<=dp_free && !squash_valid; if dp_accept is low, no lane is written.
REQ-007 Lane i tag = (tail+i) mod DEPTH, driven combinationally whether or not accepted; on accept each lane's entry is written occupied=1, complete=0, value=0; tail advances by popcount mod DEPTH.
REQ-008 Non-contiguous dp_valid (gap before a valid lane) is illegal; the block shall drop the whole group (dp_accept=0).
REQ-009 CDB: each valid lane whose tag is occupied at the start of the cycle sets complete=1 and value=cdb_value on the edge; broadcasts to unoccupied entries are ignored; duplicate tags in one cycle: highest lane wins.
REQ-010 Retire is combinational from registered state: rt_valid[i]=1 iff entries head..head+i are all occupied and complete; stops at first incomplete entry; at most RT_W per cycle.
REQ-011 Retired entries are cleared (occupied=0, complete=0) on the edge; head advances by retire count mod DEPTH.
REQ-012 Latency: broadcast on edge k -> entry retires (if oldest) during cycle k+1 -> freed on edge k+1.
REQ-013 Squash: if squash_tag is occupied, all entries younger than squash_tag are cleared in one cycle, tail <= (squash_tag+1) mod DEPTH, count <= ((squash_tag-head) mod DEPTH)+1 - retired_this_cycle; squash_tag to an unoccupied entry is ignored.
REQ-014 Squash same cycle: dispatch suppressed; retire of older entries proceeds; CDB writes to squashed entries dropped; CDB writes to surviving entries applied.
REQ-015 Simultaneous dispatch and retire: count <= count + dispatched - retired; full with retire same cycle does not accept dispatch (REQ-005).
REQ-016 Pointer wrap: head, tail, tags wrap modulo DEPTH with no lost entries at the boundary.

Reset
REQ-017 On reset (async, any time, including mid-squash): head=0, tail=0, count=0, all entries cleared; outputs: rt_valid=0, rt_tag/rt_dest/rt_value/rt_has_dest=0, dp_accept=0, dp_free=DEPTH, head_tag=0, dp_tag lane i = i.
REQ-018 First edge after reset deassertion behaves as a normal cycle; no state survives reset.

Verification (DEPTH=8, DP_W=2, RT_W=2, CDB_W=2)
REQ-019 Reset, dispatch 2 lanes x4 cycles -> tags 0..7, count=8, dp_free=0; next 1-lane request -> dp_accept=0, count stays 8.
REQ-020 Tags 0,1,2 occupied; CDB tags 1 and 0 same cycle -> next cycle rt_valid=2'b11 tags 0,1 with correct values; tag 2 incomplete -> only 2 retire, head_tag=2.
REQ-021 Complete tag 1 only (tag 0 pending) -> rt_valid=0; then complete tag 0 -> both retire in one cycle.
REQ-022 Head=6, dispatch 4 entries -> tags 6,7,0,1; all complete -> retire 6,7 then 0,1; head_tag=2, count=0.
REQ-023 Tags 0..5 occupied, squash_tag=2 with 2-lane dispatch and CDB to tag 4 same cycle -> dp_accept=0, count=3, tail=3, tag 4 not complete; next dispatch gets tags 3,4.
REQ-024 Assert reset mid-stream with count=5 -> outputs immediately at REQ-017 values; post-reset dispatch gets tags 0,1.
